// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and types for the FIFO read-side drain stage
package fifo_pkg;
   localparam int FIFO_DATA_WIDTH = 8;

   localparam int SKID_DEPTH = 3;

   typedef logic [$clog2(SKID_DEPTH+1)-1:0] occ_t;
   typedef logic [1:0]                      ptr_t;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(SKID_DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
   endfunction
endpackage

// File: rtl/fifo_skid_buf.sv
// rtl/fifo_skid_buf.sv - 3-entry circular buffer with push/pop, occupancy and head data
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output occ_t                  occ_o,
   output logic [DATA_WIDTH-1:0] head_o
);

   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t rd_ptr_q, rd_ptr_d;
   occ_t occ_q, occ_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q + occ_t'(push_i) - occ_t'(pop_i);
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
   end

   // Storage is cleared on reset so the head reads zero before any capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push_i) mem_q[wr_ptr_q] <= push_data_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign occ_o  = occ_q;
   assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - drains the async FIFO read port into a framed valid/ready stream
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int BURST_LEN  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  rd_clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [CNT_WIDTH-1:0]  word_cnt,
   output logic                  busy
);

   localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

   occ_t                 occ;
   logic                 inflight_q, inflight_d;
   logic [7:0]           beat_q, beat_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [2:0]           pending;
   logic                 hs;

   fifo_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
      .clk         (rd_clk),
      .rst         (rst),
      .push_i      (inflight_q),
      .push_data_i (fifo_rdata),
      .pop_i       (hs),
      .occ_o       (occ),
      .head_o      (m_data)
   );

   assign m_valid = (occ != '0);

   // Pops are reserved against words already buffered plus the one in flight,
   // so the buffer can never overflow and m_ready has no path to fifo_rd_en.
   always_comb begin
      pending    = {1'b0, occ} + {2'b00, inflight_q};
      fifo_rd_en = !rst && !fifo_empty && (pending < 3'(SKID_DEPTH));
      hs         = m_valid && m_ready;
      inflight_d = fifo_rd_en;
      beat_d     = beat_q;
      cnt_d      = cnt_q;
      if (hs) begin
         cnt_d  = cnt_q + CNT_WIDTH'(1);
         beat_d = (beat_q == LAST_BEAT) ? 8'd0 : beat_q + 8'd1;
      end
   end

   always_ff @(posedge rd_clk or posedge rst) begin
      if (rst) begin
         inflight_q <= 1'b0;
         beat_q     <= '0;
         cnt_q      <= '0;
      end else begin
         inflight_q <= inflight_d;
         beat_q     <= beat_d;
         cnt_q      <= cnt_d;
      end
   end

   assign m_last   = m_valid && (beat_q == LAST_BEAT);
   assign word_cnt = cnt_q;
   assign busy     = (occ != '0) || inflight_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - randomized self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;

   logic rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   logic       rst = 1'b1;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_rdata = 8'h00;
   logic       m_ready = 1'b0;

   logic        rd_en_a, valid_a, last_a, busy_a;
   logic [7:0]  data_a;
   logic [15:0] cnt_a;
   logic        rd_en_b, valid_b, last_b, busy_b;
   logic [7:0]  data_b;
   logic [3:0]  cnt_b;

   fifo_rd_stream #(.DATA_WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(16)) dut_a (
      .rd_clk(rd_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
      .fifo_rd_en(rd_en_a), .m_valid(valid_a), .m_ready(m_ready), .m_data(data_a),
      .m_last(last_a), .word_cnt(cnt_a), .busy(busy_a));

   fifo_rd_stream #(.DATA_WIDTH(8), .BURST_LEN(1), .CNT_WIDTH(4)) dut_b (
      .rd_clk(rd_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
      .fifo_rd_en(rd_en_b), .m_valid(valid_b), .m_ready(m_ready), .m_data(data_b),
      .m_last(last_b), .word_cnt(cnt_b), .busy(busy_b));

   int n_chk = 0;
   int n_pass = 0;

   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int  pops_m = 0;
   int  hs_m = 0;
   bit  infl_m = 0;
   int  rd_pulses, hs_cnt, last_hits_b, underflows, cyc, first_hs, last_hs;
   logic [15:0] last_mask_a;
   bit  rand_wr = 0;
   bit  rand_ready = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge rd_clk);
      #2;
   endtask

   task automatic push(input logic [7:0] v);
      fifo_q.push_back(v);
      exp_q.push_back(v);
      fifo_empty = 1'b0;
   endtask

   task automatic clear_stats();
      rd_pulses = 0; hs_cnt = 0; got_q.delete();
      last_mask_a = '0; last_hits_b = 0; first_hs = -1; last_hs = -1;
   endtask

   task automatic wait_hs(input int n, input int budget);
      int k;
      k = 0;
      while (hs_cnt < n && k < budget) begin
         cycles(1);
         k++;
      end
      check("wait_hs_budget", hs_cnt >= n, 1);
   endtask

   // Model: outstanding = pops issued - words delivered (buffer + in flight);
   // buffered = outstanding minus the word popped last cycle.
   int  outst, occ_m;
   bit  e_rd, e_valid, rd_now, hs_now, inv_ok;
   always begin
      @(negedge rd_clk);
      rd_now = 1'b0;
      hs_now = 1'b0;
      if (!rst) begin
         outst   = pops_m - hs_m;
         occ_m   = outst - int'(infl_m);
         e_rd    = (fifo_q.size() != 0) && (outst < 3);
         e_valid = occ_m > 0;
         check("rd_en_a", rd_en_a, e_rd);
         check("rd_en_b", rd_en_b, e_rd);
         check("valid_a", valid_a, e_valid);
         check("valid_b", valid_b, e_valid);
         check("busy_a", busy_a, outst > 0);
         check("busy_b", busy_b, outst > 0);
         check("cnt_a", cnt_a, hs_m % 65536);
         check("cnt_b", cnt_b, hs_m % 16);
         check("last_a", last_a, e_valid && (hs_m % 4 == 3));
         check("last_b", last_b, e_valid);
         if (e_valid && exp_q.size() > 0) begin
            check("data_a", data_a, exp_q[0]);
            check("data_b", data_b, exp_q[0]);
         end
         inv_ok = ({1'b0, dut_a.occ} + {2'b00, dut_a.inflight_q}) <= 3'd3;
         occ_inv: assert (inv_ok);
         check("occ_inv_a", inv_ok, 1);
         rd_now = rd_en_a;
         hs_now = valid_a && m_ready;
         if (hs_now) begin
            hs_cnt++;
            got_q.push_back(data_a);
            if (last_a) last_mask_a[data_a[3:0]] = 1'b1;
            if (last_b) last_hits_b++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
         end
      end
      @(posedge rd_clk);
      #1;
      cyc++;
      if (!rst) begin
         if (rd_now) begin
            rd_pulses++;
            if (fifo_q.size() == 0) underflows++;
            else fifo_rdata = fifo_q.pop_front();
         end
         pops_m += int'(rd_now);
         if (hs_now) begin
            hs_m++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         infl_m = rd_now;
      end
      if (rand_wr && $urandom_range(0, 1) == 1) begin
         fifo_q.push_back(8'($urandom));
         exp_q.push_back(fifo_q[fifo_q.size()-1]);
      end
      if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
      fifo_empty = (fifo_q.size() == 0);
   end

   initial begin
      int k;
      underflows = 0; cyc = 0;
      clear_stats();

      // reset state
      repeat (3) @(posedge rd_clk);
      #1;
      check("rst_rd_en", rd_en_a, 0);
      check("rst_valid", valid_a, 0);
      check("rst_data", data_a, 0);
      check("rst_last", last_a, 0);
      check("rst_cnt", cnt_a, 0);
      check("rst_busy", busy_a, 0);
      @(negedge rd_clk);
      #1 rst = 1'b0;
      cycles(1);

      // streaming 0x00..0x0F at full rate
      clear_stats();
      for (int i = 0; i < 16; i++) push(8'(i));
      m_ready = 1'b1;
      wait_hs(16, 100);
      check("stream_cnt", cnt_a, 16);
      check("stream_last_mask", last_mask_a, 16'h8888);
      check("stream_back_to_back", last_hs - first_hs, 15);
      check("stream_last_word", got_q[15], 8'h0F);

      // backpressure
      m_ready = 1'b0;
      cycles(2);
      clear_stats();
      for (int i = 0; i < 8; i++) push(8'(i));
      cycles(10);
      check("bp_pulses", rd_pulses, 3);
      check("bp_valid", valid_a, 1);
      check("bp_data", data_a, 8'h00);
      m_ready = 1'b1;
      wait_hs(8, 100);
      check("bp_count", got_q.size(), 8);
      for (int i = 0; i < 8 && i < got_q.size(); i++) check("bp_order", got_q[i], i);

      // single word in the FIFO
      cycles(2);
      clear_stats();
      push(8'h5A);
      cycles(10);
      check("empty_pulses", rd_pulses, 1);
      check("empty_hs", hs_cnt, 1);
      check("empty_word", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h5A);

      // reset with two words buffered and one in flight
      m_ready = 1'b0;
      clear_stats();
      for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
      k = 0;
      while (rd_pulses < 3 && k < 20) begin cycles(1); k++; end
      @(negedge rd_clk);
      #1;
      check("pre_rst_pending", pops_m - hs_m, 3);
      check("pre_rst_inflight", infl_m, 1);
      rst = 1'b1;
      fifo_q.delete(); exp_q.delete();
      pops_m = 0; hs_m = 0; infl_m = 0;
      fifo_empty = 1'b1;
      #1;
      check("mid_rst_valid", valid_a, 0);
      check("mid_rst_data", data_a, 0);
      check("mid_rst_busy", busy_a, 0);
      check("mid_rst_cnt_a", cnt_a, 0);
      check("mid_rst_cnt_b", cnt_b, 0);
      check("mid_rst_last_b", last_b, 0);
      repeat (2) @(negedge rd_clk);
      #1 rst = 1'b0;
      cycles(1);

      // 17 words after reset: fresh data first, narrow counter wraps
      clear_stats();
      push(8'hA5);
      for (int i = 1; i < 17; i++) push(8'(i));
      m_ready = 1'b1;
      wait_hs(17, 100);
      check("post_rst_first", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'hA5);
      check("wrap_cnt_b", cnt_b, 1);
      check("wrap_cnt_a", cnt_a, 17);
      check("wrap_last_b", last_hits_b, 17);

      // random traffic, then drain
      clear_stats();
      rand_wr = 1; rand_ready = 1;
      cycles(1000);
      rand_wr = 0; rand_ready = 0;
      cycles(1);
      m_ready = 1'b1;
      k = 0;
      while ((exp_q.size() != 0 || pops_m != hs_m) && k < 2000) begin cycles(1); k++; end
      check("rand_drained", exp_q.size(), 0);
      check("rand_idle_busy", busy_a, 0);
      check("underflows", underflows, 0);
      check("rand_traffic", hs_cnt > 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain stage for the asynchronous FIFO, in the `rd_clk` domain. Pops words from the FIFO read port with the FIFO's one-cycle read latency and presents them as a valid/ready stream. Framing is fixed-length bursts with a last marker. A 3-entry output buffer sustains one word per cycle and never pops an empty FIFO, so the FIFO's `underflow` never fires because of this block.

## Interface
- `DATA_WIDTH`, default 8: FIFO word width; must match the FIFO build.
- `BURST_LEN`, default 4: beats per burst; `m_last` marks beat `BURST_LEN-1`; legal values 1..256.
- `CNT_WIDTH`, default 16: width of the delivered-word counter.

Ports:
- `rd_clk`  in  1  FIFO read clock; the only clock in this block.
- `rst`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag, `rd_clk` domain.
- `fifo_rdata`  in  DATA_WIDTH  FIFO read data; valid the cycle after `fifo_rd_en`.
- `fifo_rd_en`  out  1  FIFO pop request.
- `m_valid`  out  1  output word available.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  DATA_WIDTH  output word.
- `m_last`  out  1  final beat of the current burst.
- `word_cnt`  out  CNT_WIDTH  count of completed output handshakes; wraps.
- `busy`  out  1  buffer non-empty or a read is in flight.

## Operation
- Reset values: `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `word_cnt`=0, `busy`=0. Buffer occupancy, in-flight flag and beat counter are all cleared.
- **Pop rule:** `fifo_rd_en = !fifo_empty && (occ + inflight < 3)`.
  - `occ` is the registered buffer occupancy, 0..3.
  - `inflight` is a registered copy of the previous cycle's `fifo_rd_en`.
  - `fifo_rd_en` is combinational only from registers and `fifo_empty`; it has no path from `m_ready`.
- **Capture:** when `inflight`=1, `fifo_rdata` is written into the buffer tail at that edge.
- **Output:**
  - `m_valid` is high while `occ > 0`, and `m_data` shows the buffer head. Both come from registered state.
  - Handshake is `m_valid && m_ready`. It pops the head, increments `word_cnt`, and advances the beat counter.
- **Occupancy update:** `occ_next = occ + inflight - handshake`. Simultaneous capture and pop leave `occ` unchanged. The occupancy invariant `occ + inflight <= 3` must always hold; the bench checks it as an assertion.
- **Framing:**
  - The beat counter runs 0..BURST_LEN-1 and wraps to 0 on the handshake of the last beat.
  - `m_last = m_valid && (beat == BURST_LEN-1)`.
  - For `BURST_LEN=1`, `m_last` is high on every valid beat.
- **Valid/data stability:** while `m_valid && !m_ready`, `m_data` and `m_last` hold stable and `m_valid` stays high.
- **`busy`:** `busy = (occ != 0) || inflight`.
- **Reset mid-operation:** the buffer is cleared and any in-flight FIFO word is discarded; the FIFO's own reset empties it together with this block. The beat counter restarts at 0.

## Timing
- **Latency:** `fifo_rd_en` high in cycle N → `fifo_rdata` captured at the end of N+1 → `m_valid` high in N+2, with an empty buffer.
- **Throughput:** with `m_ready` held high and the FIFO non-empty, one word per cycle indefinitely.
- **Backpressure:** with `m_ready` low, at most 3 pops are issued before `fifo_rd_en` drops. Popping resumes in the cycle after the first handshake frees space.
- **FIFO going empty:** if `fifo_empty` rises, no further pops are issued. Already in-flight data is still delivered.
- `word_cnt` updates on the clock edge of the handshake and wraps from 2^CNT_WIDTH-1 to 0.

## Structure
- Package `fifo_pkg` holds:
  - the `DATA_WIDTH` default, matching the codebase-wide `` `DATA_WIDTH ``;
  - localparam `SKID_DEPTH = 3`;
  - the occupancy type `logic [1:0]` (width $clog2(SKID_DEPTH+1) = 2, holding 0..3).
- Sub-module `fifo_skid_buf`: 3-entry circular buffer with push/pop/occ and head data; no framing.
- The top level holds the pop rule, the in-flight register, the beat counter and `word_cnt`.

## Test plan
- **Reset:** assert `rst` mid-stream with 2 words buffered and 1 in flight → all outputs 0 immediately. After release, the first word out is the FIFO's next word, not a stale one.
- **Streaming:** FIFO preloaded with 0x00..0x0F, `m_ready`=1 → `m_data` 0x00..0x0F on 16 consecutive cycles. With `BURST_LEN=4`, `m_last` is high on 0x03, 0x07, 0x0B and 0x0F; `word_cnt`=16.
- **Backpressure:** FIFO holds 8 words, `m_ready`=0 for 10 cycles → exactly 3 `fifo_rd_en` pulses and `m_data`=0x00 held stable. After `m_ready`=1, words 0x00..0x07 arrive in order with no loss.
- **Empty boundary:** FIFO has 1 word → exactly one `fifo_rd_en` pulse. `fifo_rd_en` is never high while `fifo_empty`=1 over 1000 random cycles, and the FIFO's `underflow` stays 0.
- **Counter wrap:** `CNT_WIDTH=4`, deliver 17 words → `word_cnt`=1. With `BURST_LEN=1`, `m_last` is high on all 17 beats.
- **Random:** random `m_ready` and random FIFO writes; the scoreboard matches write order to output order, and the `occ + inflight <= 3` assertion never fails.
